// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: state encoding, default sizes,
// digit width, and a constant helper used for the elaboration-time range check.
package bcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OP   = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int BIN_W_DEF = 20;
  localparam int NDIG_DEF  = 7;
  localparam int DIG_W     = 4;

  // 10^n as a 64-bit constant; only used at elaboration time.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a BCD digit above 4 gets 3 added before the shift
// so that it carries correctly into the next decade.
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adjusted
);

  assign adjusted = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd20.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock; fed from the
// Fibonacci unit (bin <= f, start <= its done_tick). Optional blank output: BIN2BCD_BLANK_EN.
module bin2bcd20
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    ready,
  output logic                    done_tick,
  output logic [DIG_W*NDIG-1:0]   bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [NDIG-1:0]         blank
`endif
);

  localparam int BCD_W = DIG_W * NDIG;
  localparam int N_W   = $clog2(BIN_W + 1);
  localparam bit FITS  = pow10(NDIG) > ((64'd1 << BIN_W) - 64'd1);

  generate
    if (!FITS) begin : g_ndig_check
      $error("bin2bcd20: NDIG digits cannot represent 2^BIN_W-1");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] work_reg;
  logic [N_W-1:0]   n_reg;
  logic [BCD_W-1:0] bcd_reg;

  logic [BCD_W-1:0] work_adj;
  logic [BCD_W-1:0] work_shift;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .digit    (work_reg[DIG_W*gi +: DIG_W]),
        .adjusted (work_adj[DIG_W*gi +: DIG_W])
      );
    end
  endgenerate

  // The top adjusted bit always falls off: the range check keeps the top digit below 5.
  assign work_shift = {work_adj[BCD_W-2:0], shift_reg[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
  logic [NDIG-1:0] blank_reg;
  logic [NDIG-1:0] blank_calc;

  // Digit 0 is never blanked so a zero result still shows a single "0".
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_calc[gi] = 1'b0;
      end else begin : g_upper
        assign blank_calc[gi] = ~|work_shift[BCD_W-1:DIG_W*gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_reg <= {{(NDIG-1){1'b1}}, 1'b0};
    end else if (state_reg == ST_OP && n_reg == N_W'(1)) begin
      blank_reg <= blank_calc;
    end
  end

  assign blank = blank_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      work_reg  <= '0;
      n_reg     <= '0;
      bcd_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= bin;
            work_reg  <= '0;
            n_reg     <= N_W'(BIN_W);
            state_reg <= ST_OP;
          end
        end
        ST_OP: begin
          work_reg  <= work_shift;
          shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
          n_reg     <= n_reg - N_W'(1);
          if (n_reg == N_W'(1)) begin
            bcd_reg   <= work_shift;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_reg == ST_IDLE);
  assign done_tick = (state_reg == ST_DONE);
  assign bcd       = bcd_reg;

endmodule

// File: tb/tb_bin2bcd20.sv
// Directed bench for bin2bcd20: latency, results, blanking (when BIN2BCD_BLANK_EN),
// start masking, mid-conversion reset and back-to-back operation.
module tb_bin2bcd20;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] bin;
  logic        ready;
  logic        done_tick;
  logic [27:0] bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [6:0]  blank;
`endif

  int total = 0;
  int bad   = 0;

  bin2bcd20 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank     (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_blank(input string tag, input logic [6:0] exp);
`ifdef BIN2BCD_BLANK_EN
    check(tag, 32'(blank), 32'(exp));
`endif
  endtask

  // One conversion; optional start pulse injected during op cycle inj_k.
  task automatic conv(input logic [19:0] b, input logic [27:0] exp_bcd, input logic [6:0] exp_blank,
                      input logic [27:0] prev_bcd, input int inj_k, input logic [19:0] inj_b);
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 20'hABCDE;
    check("busy", 32'(ready), 32'd0);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      if (k == inj_k) begin
        start = 1'b1;
        bin   = inj_b;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_tick) lat = k + 1;
      else if (k == 10) check("bcd_hold", 32'(bcd), 32'(prev_bcd));
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd21);
    check("bcd", 32'(bcd), 32'(exp_bcd));
    check_blank("blank", exp_blank);
    $display("conv bin=%0d bcd=%h latency=%0d", b, bcd, lat);
    @(posedge clk); #1;
    check("pulse_width", 32'(done_tick), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    int seen;
    int k1;
    int k2;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check_blank("rst_blank", 7'b1111110);
    @(negedge clk);
    reset = 1'b0;

    conv(20'd0,       28'h0000000, 7'b1111110, 28'h0000000, 0, 20'd0);
    conv(20'd6765,    28'h0006765, 7'b1110000, 28'h0000000, 0, 20'd0);
    conv(20'd1048575, 28'h1048575, 7'b0000000, 28'h0006765, 0, 20'd0);
    conv(20'd6765,    28'h0006765, 7'b1110000, 28'h1048575, 5, 20'd99);
    @(posedge clk); #1;
    check("idle_after_ignored", 32'(ready), 32'd1);

    // Reset during op cycle 10 of a 12345 conversion.
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd12345;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check_blank("abort_blank", 7'b1111110);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_tick) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    $display("abort bin=12345 bcd=%h done_seen=%0d", bcd, seen);
    conv(20'd12345, 28'h0012345, 7'b1100000, 28'h0000000, 0, 20'd0);

    // Start held high: two conversions back to back.
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd89;
    k1 = -1;
    k2 = -1;
    for (int k = 1; k <= 60 && k2 < 0; k++) begin
      @(posedge clk); #1;
      if (done_tick) begin
        if (k1 < 0) begin
          k1 = k;
          check("b2b_bcd1", 32'(bcd), 32'h0000089);
          check_blank("b2b_blank1", 7'b1111100);
          bin = 20'd144;
        end else begin
          k2 = k;
          check("b2b_bcd2", 32'(bcd), 32'h0000144);
          check_blank("b2b_blank2", 7'b1111000);
          start = 1'b0;
        end
      end else if (k1 >= 0) begin
        check("b2b_hold", 32'(bcd), 32'h0000089);
      end
    end
    start = 1'b0;
    check("b2b_first", 32'(k1), 32'd21);
    check("b2b_gap", 32'(k2 - k1), 32'd22);
    $display("back2back first=%0d second=%0d bcd=%h", k1, k2, bcd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
